// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse_meter receiver.
// Optional glitch filtering is selected with PULSE_METER_GLITCH_FILTER_EN.
package pulse_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Saturation value for a counter of the given width (all ones).
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/pulse_meter_if.sv
// Result/handshake bundle between pulse_meter and its consumer.
interface pulse_meter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             overflow;
  logic             overrun;
  logic             ack;

  modport master (
    output period, high_time, valid, overflow, overrun,
    input  ack
  );

  modport slave (
    input  period, high_time, valid, overflow, overrun,
    output ack
  );
endinterface

// File: rtl/pulse_meter_edge_sync.sv
// Synchroniser, optional glitch filter and rising-edge detector for an async input.
// Define PULSE_METER_GLITCH_FILTER_EN to reject single-cycle glitches.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lvl_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

`ifdef PULSE_METER_GLITCH_FILTER_EN
  logic lvl_q;
  logic pend_q;

  // lvl follows the synchronised input only after two consecutive differing samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q  <= 1'b0;
      pend_q <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1] != lvl_q) begin
      if (pend_q) begin
        lvl_q  <= sync_q[SYNC_STAGES-1];
        pend_q <= 1'b0;
      end else begin
        pend_q <= 1'b1;
      end
    end else begin
      pend_q <= 1'b0;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lvl_d <= 1'b0;
    else          lvl_d <= lvl;
  end

  assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/pulse_meter.sv
// Measures period and high time of an async pulse train in clock cycles,
// holding each result under valid/ack. Glitch filter: PULSE_METER_GLITCH_FILTER_EN.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           signal,
  input  logic           clear,
  pulse_meter_if.master  res
);

  localparam logic [WIDTH-1:0] SAT = WIDTH'(sat_max(WIDTH));

  state_t           state_q, state_d;
  logic             lvl, rise, publish;
  logic [WIDTH-1:0] cnt, hcnt;
  logic             ovf;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (signal),
    .lvl     (lvl),
    .rise    (rise)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else if (rise) begin
      state_d = MEASURE;
      publish = (state_q == MEASURE);
    end
  end

  // The rise cycle opens the new window, so both counters restart at 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      hcnt <= '0;
      ovf  <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      hcnt <= '0;
      ovf  <= 1'b0;
    end else if (rise) begin
      cnt  <= WIDTH'(1);
      hcnt <= WIDTH'(1);
      ovf  <= 1'b0;
    end else begin
      if (cnt != SAT) cnt <= cnt + WIDTH'(1);
      else            ovf <= 1'b1;
      if (lvl) begin
        if (hcnt != SAT) hcnt <= hcnt + WIDTH'(1);
        else             ovf  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res.period    <= '0;
      res.high_time <= '0;
      res.valid     <= 1'b0;
      res.overflow  <= 1'b0;
      res.overrun   <= 1'b0;
    end else if (clear) begin
      res.valid    <= 1'b0;
      res.overflow <= 1'b0;
      res.overrun  <= 1'b0;
    end else if (publish) begin
      if (!res.valid || res.ack) begin
        res.period    <= cnt;
        res.high_time <= hcnt;
        res.overflow  <= ovf;
        res.valid     <= 1'b1;
      end else begin
        res.overrun <= 1'b1;
      end
    end else if (res.ack) begin
      res.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed and randomized checks of pulse_meter against a waveform-level reference model.
module tb_pulse_meter;

  typedef struct {
    int unsigned period;
    int unsigned high;
    bit          ovf;
  } meas_t;

  logic clock = 1'b0;
  logic reset_n;
  logic signal;
  logic clear;

  pulse_meter_if #(.WIDTH(8)) res ();

  pulse_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .signal  (signal),
    .clear   (clear),
    .res     (res)
  );

  always #5 clock = ~clock;

  meas_t       q[$];
  meas_t       front;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned results_seen = 0;
  int unsigned seen0;
  bit          mon_en = 1'b0;
  bit          sig_cur = 1'b0;

  // Reference model: effective level, window length and high cycles between rising edges.
  bit          m_eff, m_prev, m_armed;
  int unsigned m_run, m_cnt, m_hcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_eff = 1'b0; m_prev = 1'b0; m_run = 0;
    m_armed = 1'b0; m_cnt = 0; m_hcnt = 0;
    q.delete();
  endtask

  task automatic model_clear();
    m_armed = 1'b0; m_cnt = 0; m_hcnt = 0;
    q.delete();
  endtask

  task automatic model_step(input bit x);
    meas_t e;
`ifdef PULSE_METER_GLITCH_FILTER_EN
    if (x != m_eff) begin
      m_run++;
      if (m_run == 2) begin
        m_eff = x;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
`else
    m_eff = x;
`endif
    if (m_eff && !m_prev) begin
      if (m_armed) begin
        e.period = (m_cnt > 255) ? 255 : m_cnt;
        e.high   = (m_hcnt > 255) ? 255 : m_hcnt;
        e.ovf    = (m_cnt > 255) || (m_hcnt > 255);
        q.push_back(e);
      end
      m_armed = 1'b1;
      m_cnt = 0;
      m_hcnt = 0;
    end
    m_prev = m_eff;
    m_cnt++;
    if (m_eff) m_hcnt++;
  endtask

  task automatic tick(input bit v);
    meas_t e;
    @(negedge clock);
    if (mon_en && res.valid === 1'b1) begin
      results_seen++;
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_result observed=valid expected=no_result period=%0d", res.period);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("period", res.period, e.period);
        chk("high_time", res.high_time, e.high);
        chk("overflow", 32'(res.overflow), 32'(e.ovf));
      end
    end
    signal = v;
    sig_cur = v;
    model_step(v);
  endtask

  task automatic seg(input bit v, input int unsigned n);
    repeat (n) tick(v);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    model_clear();
    tick(sig_cur);
    clear = 1'b0;
  endtask

  initial begin
    int unsigned h, l;
    reset_n = 1'b0;
    signal = 1'b0;
    clear = 1'b0;
    res.ack = 1'b1;
    model_reset();

    // Reset state
    seg(0, 3);
    chk("rst_period", res.period, 0);
    chk("rst_high", res.high_time, 0);
    chk("rst_valid", 32'(res.valid), 0);
    chk("rst_overflow", 32'(res.overflow), 0);
    chk("rst_overrun", 32'(res.overrun), 0);
    reset_n = 1'b1;
    model_reset();
    seg(0, 3);

    // Period 4, 50% duty, ack held high
    mon_en = 1'b1;
    seen0 = results_seen;
    repeat (12) begin
      seg(1, 2);
      seg(0, 2);
    end
    seg(0, 8);
    chk("p4_results", results_seen - seen0, 11);
    chk("p4_overrun", 32'(res.overrun), 0);
    chk("p4_drained", q.size(), 0);

    // Random periods
    repeat (20) begin
      h = $urandom_range(12, 2);
      l = $urandom_range(12, 2);
      seg(1, h);
      seg(0, l);
    end
    seg(1, 2);
    seg(0, 8);
    chk("rand_drained", q.size(), 0);

    // Saturation then recovery
    seg(1, 150);
    seg(0, 150);
    seg(1, 10);
    seg(0, 10);
    seg(1, 2);
    seg(0, 8);
    chk("ovf_drained", q.size(), 0);

    // Constant input produces no result, then measurement resumes
    seg(1, 10);
    seen0 = results_seen;
    seg(1, 990);
    chk("const_no_result", results_seen - seen0, 0);
    seg(0, 5);
    seg(1, 4);
    seg(0, 4);
    seg(1, 2);
    seg(0, 8);
    chk("const_drained", q.size(), 0);

    // Overrun with ack low, then ack, then clear
    mon_en = 1'b0;
    res.ack = 1'b0;
    pulse_clear();
    chk("clr_valid", 32'(res.valid), 0);
    seg(1, 3);
    seg(0, 7);
    seg(1, 5);
    seg(0, 7);
    front = q[0];
    chk("hold_valid", 32'(res.valid), 1);
    chk("hold_period", res.period, front.period);
    chk("hold_high", res.high_time, front.high);
    chk("hold_overrun", 32'(res.overrun), 0);
    seg(1, 5);
    seg(0, 6);
    chk("ovr_valid", 32'(res.valid), 1);
    chk("ovr_period", res.period, front.period);
    chk("ovr_high", res.high_time, front.high);
    chk("ovr_overrun", 32'(res.overrun), 1);
    res.ack = 1'b1;
    tick(0);
    res.ack = 1'b0;
    chk("ack_valid", 32'(res.valid), 0);
    chk("ack_overrun", 32'(res.overrun), 1);
    seg(0, 3);
    pulse_clear();
    chk("clr2_overrun", 32'(res.overrun), 0);
    chk("clr2_valid", 32'(res.valid), 0);
    chk("clr2_overflow", 32'(res.overflow), 0);
    chk("clr2_period_kept", res.period, front.period);
    res.ack = 1'b1;
    mon_en = 1'b1;
    seen0 = results_seen;
    seg(1, 4);
    seg(0, 6);
    chk("clr_arm_only", results_seen - seen0, 0);
    seg(1, 4);
    seg(0, 6);
    seg(1, 2);
    seg(0, 8);
    chk("clr_resume", results_seen - seen0, 2);

    // Single-cycle low glitches inside the high phase
    seen0 = results_seen;
    repeat (4) begin
      seg(1, 2);
      seg(0, 1);
      seg(1, 3);
      seg(0, 6);
    end
    seg(1, 2);
    seg(0, 8);
`ifdef PULSE_METER_GLITCH_FILTER_EN
    chk("glitch_results", results_seen - seen0, 5);
`else
    chk("glitch_results", results_seen - seen0, 9);
`endif
    chk("glitch_drained", q.size(), 0);

    // Asynchronous reset while a result is held
    mon_en = 1'b0;
    res.ack = 1'b0;
    pulse_clear();
    seg(1, 4);
    seg(0, 4);
    seg(1, 4);
    seg(0, 8);
    front = q[0];
    chk("pre_rst_valid", 32'(res.valid), 1);
    chk("pre_rst_period", res.period, front.period);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_period", res.period, 0);
    chk("arst_high", res.high_time, 0);
    chk("arst_valid", 32'(res.valid), 0);
    chk("arst_overflow", 32'(res.overflow), 0);
    chk("arst_overrun", 32'(res.overrun), 0);
    seg(0, 3);
    reset_n = 1'b1;
    model_reset();
    res.ack = 1'b1;
    mon_en = 1'b1;
    seen0 = results_seen;
    seg(1, 5);
    seg(0, 5);
    chk("arst_arm_only", results_seen - seen0, 0);
    seg(1, 5);
    seg(0, 5);
    seg(1, 2);
    seg(0, 8);
    chk("arst_resume", results_seen - seen0, 2);
    chk("final_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Receiving end of the team's pulse/clock-divider generators.
- Samples an external pulse train, synchronises it to `clock`, detects rising edges, and measures period and high time in `clock` cycles.
- Holds each result under a valid/ack handshake for a consumer such as a bench monitor or register block.
- Sits beside the pulse generators in the timing chapters; it closes the loop on divided-clock outputs.

Parameters:
- WIDTH, 8, width of the period and high-time counters and results.
- SYNC_STAGES, 2, number of synchroniser flops on `signal` (minimum 2).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- signal  input  1  pulse train under measurement, asynchronous to `clock`.
- clear  input  1  synchronous restart of measurement; also clears flags.
- ack  input  1  consumer accepts the current result.
- period  output  WIDTH  cycles between the last two rising edges.
- high_time  output  WIDTH  cycles the synchronised level was 1 within that period.
- valid  output  1  result held on period/high_time.
- overflow  output  1  the held result saturated.
- overrun  output  1  sticky: a measurement was lost while valid and not ack.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - period=0, high_time=0, valid=0, overflow=0, overrun=0.
  - Synchroniser flops and counters = 0; state = IDLE.
- Input path:
  - `signal` passes through SYNC_STAGES flops, giving `lvl`.
  - A rising edge is `rise` = lvl & ~lvl_d (one extra flop).
  - Latency from a `signal` edge to `rise`: SYNC_STAGES+1 cycles.
- States:
  - IDLE: waits for the first `rise`, then goes to MEASURE. No result is produced on the first edge.
  - MEASURE: on each `rise`, publishes a result and stays in MEASURE.
- Counters:
  - `cnt` counts cycles since the last `rise`.
  - `hcnt` counts cycles with lvl=1 in the same window.
  - Window: the `rise` cycle is included; the next `rise` cycle is excluded.
  - Both saturate at 2^WIDTH-1; an `ovf` bit records saturation.
- Publish on `rise` in MEASURE:
  - period←cnt, high_time←hcnt, overflow←ovf.
  - Counters restart for the new window; ovf is cleared.
- Handshake:
  - valid rises the cycle after the publish and stays high until `ack`.
  - ack=1 with valid=1 clears valid at that edge.
  - ack while valid=0 is ignored.
- Publish while valid=1 and ack=0:
  - Old result is kept; the new one is dropped.
  - overrun←1 (sticky).
- Publish coincident with ack=1:
  - New result loads; valid stays 1; no overrun.
- Constant input: if `signal` is held constant, counters saturate and no result is produced; valid is unchanged.
- clear=1:
  - Next state IDLE; counters=0; valid=0; overflow=0; overrun=0.
  - period/high_time keep their last values.
  - clear has priority over rise and ack.
- reset_n asserted mid-measurement aborts immediately to the reset values. After release, the first edge is again an IDLE arm edge.
- Minimum measurable period is 2 cycles. The bench does not check shorter input periods.

Optional Feature:
- Macro: PULSE_METER_GLITCH_FILTER_EN.
- Defined:
  - `lvl` changes only after the synchronised input differs from `lvl` for 2 consecutive cycles.
  - Single-cycle glitches are ignored.
  - `rise` latency becomes SYNC_STAGES+3.
  - Minimum measurable period becomes 4 cycles.
- Undefined: `lvl` is the raw synchroniser output, as described above.

Decomposition:
- Package pulse_meter_pkg:
  - State encoding constants IDLE=1'b0, MEASURE=1'b1.
  - Saturation constant (all-ones of WIDTH).
- Sub-module edge_sync:
  - Contains the SYNC_STAGES synchroniser, the optional glitch filter, and the rise detector.
  - Outputs `lvl` and `rise`.
  - Reusable by later receivers.

Test Plan:
- Period-4, 50% stimulus: `signal` toggles every 2 negedges from a divide-by-4 pulse generator, ack held 1 → after the second detected edge, period=4, high_time=2, overflow=0; repeats every 4 cycles; overrun stays 0.
- Period 10, high 3 with ack=0 → first result period=10, high_time=3, valid=1. Next edge: data unchanged, overrun=1. Then pulse ack → valid=0 next cycle, overrun stays 1 until clear.
- WIDTH=8, period 300 cycles → period=255, overflow=1. Next 20-cycle period → period=20, overflow=0.
- `signal` held 1 for 1000 cycles after arming → no valid; then normal edges → correct measurement resumes. clear pulse mid-window → valid=0, overrun=0; the next edge only arms (no result).
- reset_n dropped asynchronously between clock edges mid-measurement → outputs zero immediately. After release, first result appears only after two rising edges.
- With PULSE_METER_GLITCH_FILTER_EN, a period-12 stimulus with 1-cycle low glitches inside the high phase → period=12, no spurious results. Without the macro, the same glitches produce extra results.
